// File: rtl/csr_trap_unit.sv
// csr_trap_unit
//   Machine-mode CSR file with built-in trap sequencing. It holds mstatus, mie,
//   mip, mtvec, mepc, mcause, mtval, mscratch, mcycle, minstret and mhartid. It
//   arbitrates three interrupt lines, applies the trap-entry and mret updates
//   itself, and emits a registered one-cycle PC redirect.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   cpu_csr_wen_i/waddr_i/wdata_i    CSR write port
//   cpu_csr_raddr_i, csr_rdata_o     combinational read port (write bypass)
//   instr_retire_i                   increments minstret
//   trap_valid_i, trap_cause_i,      trap entry pulse and its
//   trap_pc_i, trap_tval_i           mcause/mepc/mtval values
//   mret_i                           mret pulse
//   irq_msip_i/irq_mtip_i/irq_meip_i level interrupt lines
//   irq_req_o, irq_cause_o           highest-priority enabled pending interrupt
//   redirect_valid_o, redirect_pc_o  one-cycle fetch redirect
module csr_trap_unit #(
    parameter int XLEN   = 64,
    parameter int CNT_W  = 64,
    parameter int HARTID = 0,
    parameter int VEC_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_csr_wen_i,
    input  logic [11:0]     cpu_csr_waddr_i,
    input  logic [XLEN-1:0] cpu_csr_wdata_i,
    input  logic [11:0]     cpu_csr_raddr_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic            instr_retire_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            irq_msip_i,
    input  logic            irq_mtip_i,
    input  logic            irq_meip_i,
    output logic            irq_req_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    // Interrupt sources in the order {meip, mtip, msip}; IRQ_BIT maps each to its mie/mip bit.
    localparam int IRQ_BIT [3] = '{3, 7, 11};

    logic             mstatus_mie_reg, mstatus_mie_next;
    logic             mstatus_mpie_reg, mstatus_mpie_next;
    logic [XLEN-1:0]  mie_reg, mie_next;
    logic [XLEN-1:0]  mtvec_reg, mtvec_next;
    logic [XLEN-1:0]  mscratch_reg, mscratch_next;
    logic [XLEN-1:0]  mepc_reg, mepc_next;
    logic [XLEN-1:0]  mcause_reg, mcause_next;
    logic [XLEN-1:0]  mtval_reg, mtval_next;
    logic [2:0]       mip_reg;
    logic [CNT_W-1:0] mcycle_reg, mcycle_next;
    logic [CNT_W-1:0] minstret_reg, minstret_next;
    logic             redirect_valid_reg, redirect_valid_next;
    logic [XLEN-1:0]  redirect_pc_reg, redirect_pc_next;

    logic [XLEN-1:0]  mstatus_val, mip_val;
    logic [XLEN-1:0]  wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_cnt;
    logic [XLEN-1:0]  trap_base, trap_target;
    logic [2:0]       irq_lines, pending;
    logic             bypass, irq_req;

    assign irq_lines = {irq_meip_i, irq_mtip_i, irq_msip_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pending
            assign pending[gi] = mie_reg[IRQ_BIT[gi]] & mip_reg[gi];
        end
    endgenerate

    // Architectural views of the sparse registers, and post-WARL write values.
    always_comb begin
        mstatus_val        = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mstatus_mpie_reg;
        mstatus_val[3]     = mstatus_mie_reg;
        mip_val            = '0;
        mip_val[3]         = mip_reg[0];
        mip_val[7]         = mip_reg[1];
        mip_val[11]        = mip_reg[2];

        wr_mstatus         = '0;
        wr_mstatus[12:11]  = 2'b11;
        wr_mstatus[7]      = cpu_csr_wdata_i[7];
        wr_mstatus[3]      = cpu_csr_wdata_i[3];
        wr_mie             = '0;
        wr_mie[3]          = cpu_csr_wdata_i[3];
        wr_mie[7]          = cpu_csr_wdata_i[7];
        wr_mie[11]         = cpu_csr_wdata_i[11];
        // Only mode 0 (direct) and, when enabled, mode 1 (vectored) are legal.
        wr_mtvec           = {cpu_csr_wdata_i[XLEN-1:2], 2'b00};
        if (VEC_EN != 0 && cpu_csr_wdata_i[1:0] == 2'b01) begin
            wr_mtvec[0] = 1'b1;
        end
        wr_mepc            = {cpu_csr_wdata_i[XLEN-1:2], 2'b00};
        wr_cnt             = XLEN'(cpu_csr_wdata_i[CNT_W-1:0]);
    end

    // Read port: a same-address write in flight is returned as it will be stored.
    always_comb begin
        bypass = cpu_csr_wen_i && (cpu_csr_raddr_i == cpu_csr_waddr_i);
        case (cpu_csr_raddr_i)
            ADDR_MSTATUS:  csr_rdata_o = bypass ? wr_mstatus : mstatus_val;
            ADDR_MIE:      csr_rdata_o = bypass ? wr_mie : mie_reg;
            ADDR_MTVEC:    csr_rdata_o = bypass ? wr_mtvec : mtvec_reg;
            ADDR_MSCRATCH: csr_rdata_o = bypass ? cpu_csr_wdata_i : mscratch_reg;
            ADDR_MEPC:     csr_rdata_o = bypass ? wr_mepc : mepc_reg;
            ADDR_MCAUSE:   csr_rdata_o = bypass ? cpu_csr_wdata_i : mcause_reg;
            ADDR_MTVAL:    csr_rdata_o = bypass ? cpu_csr_wdata_i : mtval_reg;
            ADDR_MIP:      csr_rdata_o = mip_val;
            ADDR_MCYCLE:   csr_rdata_o = bypass ? wr_cnt : XLEN'(mcycle_reg);
            ADDR_MINSTRET: csr_rdata_o = bypass ? wr_cnt : XLEN'(minstret_reg);
            ADDR_MHARTID:  csr_rdata_o = XLEN'(HARTID);
            default:       csr_rdata_o = '0;
        endcase
    end

    // Interrupt arbitration: MEI > MSI > MTI. Suppressed while a trap or mret
    // is being taken so the pipeline never sees a request it cannot act on.
    always_comb begin
        irq_req     = mstatus_mie_reg & (|pending) & ~trap_valid_i & ~mret_i;
        irq_cause_o = '0;
        if (irq_req) begin
            irq_cause_o[XLEN-1] = 1'b1;
            if (pending[2]) begin
                irq_cause_o[3:0] = 4'd11;
            end else if (pending[0]) begin
                irq_cause_o[3:0] = 4'd3;
            end else begin
                irq_cause_o[3:0] = 4'd7;
            end
        end
    end
    assign irq_req_o = irq_req;

    assign trap_base   = {mtvec_reg[XLEN-1:2], 2'b00};
    assign trap_target = (mtvec_reg[0] && trap_cause_i[XLEN-1])
                         ? trap_base + {trap_cause_i[XLEN-3:0], 2'b00}
                         : trap_base;

    // Next state. CPU writes are applied first and then overridden by mret,
    // then by trap, so each CSR sees trap > mret > write.
    always_comb begin
        mstatus_mie_next    = mstatus_mie_reg;
        mstatus_mpie_next   = mstatus_mpie_reg;
        mie_next            = mie_reg;
        mtvec_next          = mtvec_reg;
        mscratch_next       = mscratch_reg;
        mepc_next           = mepc_reg;
        mcause_next         = mcause_reg;
        mtval_next          = mtval_reg;
        mcycle_next         = mcycle_reg + CNT_W'(1);
        minstret_next       = minstret_reg + CNT_W'(instr_retire_i);
        redirect_valid_next = 1'b0;
        redirect_pc_next    = redirect_pc_reg;

        if (cpu_csr_wen_i) begin
            case (cpu_csr_waddr_i)
                ADDR_MSTATUS: begin
                    mstatus_mie_next  = cpu_csr_wdata_i[3];
                    mstatus_mpie_next = cpu_csr_wdata_i[7];
                end
                ADDR_MIE:      mie_next      = wr_mie;
                ADDR_MTVEC:    mtvec_next    = wr_mtvec;
                ADDR_MSCRATCH: mscratch_next = cpu_csr_wdata_i;
                ADDR_MEPC:     mepc_next     = wr_mepc;
                ADDR_MCAUSE:   mcause_next   = cpu_csr_wdata_i;
                ADDR_MTVAL:    mtval_next    = cpu_csr_wdata_i;
                ADDR_MCYCLE:   mcycle_next   = cpu_csr_wdata_i[CNT_W-1:0];
                ADDR_MINSTRET: minstret_next = cpu_csr_wdata_i[CNT_W-1:0];
                default: ;
            endcase
        end

        if (trap_valid_i) begin
            mepc_next           = {trap_pc_i[XLEN-1:2], 2'b00};
            mcause_next         = trap_cause_i;
            mtval_next          = trap_tval_i;
            mstatus_mpie_next   = mstatus_mie_reg;
            mstatus_mie_next    = 1'b0;
            redirect_valid_next = 1'b1;
            redirect_pc_next    = trap_target;
        end else if (mret_i) begin
            mstatus_mie_next    = mstatus_mpie_reg;
            mstatus_mpie_next   = 1'b1;
            redirect_valid_next = 1'b1;
            redirect_pc_next    = mepc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_reg    <= 1'b0;
            mstatus_mpie_reg   <= 1'b0;
            mie_reg            <= '0;
            mtvec_reg          <= '0;
            mscratch_reg       <= '0;
            mepc_reg           <= '0;
            mcause_reg         <= '0;
            mtval_reg          <= '0;
            mip_reg            <= '0;
            mcycle_reg         <= '0;
            minstret_reg       <= '0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            mstatus_mie_reg    <= mstatus_mie_next;
            mstatus_mpie_reg   <= mstatus_mpie_next;
            mie_reg            <= mie_next;
            mtvec_reg          <= mtvec_next;
            mscratch_reg       <= mscratch_next;
            mepc_reg           <= mepc_next;
            mcause_reg         <= mcause_next;
            mtval_reg          <= mtval_next;
            mip_reg            <= irq_lines;
            mcycle_reg         <= mcycle_next;
            minstret_reg       <= minstret_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
        end
    end

    assign redirect_valid_o = redirect_valid_reg;
    assign redirect_pc_o    = redirect_pc_reg;

endmodule
